controller: RTL and testbench

//  Main decode/control unit of the MIPS-style pipelined core, sitting in ID.

---
 rtl/ctrl_pkg.sv | 84 ++++++++
 rtl/ctrl_decode.sv | 110 +++++++++++
 rtl/controller.sv | 81 ++++++++
 tb/tb_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants and types for the ID-stage control unit.
//  - MIPS opcode, funct and REGIMM-rt field constants
//  - ALUOp, RegDst, MemToReg, load/store width and Jump encodings
//  - ctrl_bundle_t: packed control bundle, split into the datapath part
//    (always registered) and the branch/jump part (optionally bypassed).
package ctrl_pkg;

  // Opcodes, Instruction[31:26]
  localparam logic [5:0] OpRType  = 6'b000000;
  localparam logic [5:0] OpRegimm = 6'b000001;
  localparam logic [5:0] OpJ      = 6'b000010;
  localparam logic [5:0] OpJal    = 6'b000011;
  localparam logic [5:0] OpBeq    = 6'b000100;
  localparam logic [5:0] OpBlez   = 6'b000110;
  localparam logic [5:0] OpBgtz   = 6'b000111;
  localparam logic [5:0] OpAddi   = 6'b001000;
  localparam logic [5:0] OpAndi   = 6'b001100;
  localparam logic [5:0] OpOri    = 6'b001101;
  localparam logic [5:0] OpXori   = 6'b001110;
  localparam logic [5:0] OpLb     = 6'b100000;
  localparam logic [5:0] OpLh     = 6'b100001;
  localparam logic [5:0] OpLw     = 6'b100011;
  localparam logic [5:0] OpSb     = 6'b101000;
  localparam logic [5:0] OpSh     = 6'b101001;
  localparam logic [5:0] OpSw     = 6'b101011;

  // Funct, Instruction[5:0]
  localparam logic [5:0] FunctJr = 6'b001000;

  // REGIMM rt, Instruction[20:16]
  localparam logic [4:0] RtBltz = 5'b00000;
  localparam logic [4:0] RtBgez = 5'b00001;

  // ALUOp
  localparam logic [3:0] AluAdd   = 4'b0000;
  localparam logic [3:0] AluSub   = 4'b0001;
  localparam logic [3:0] AluRType = 4'b0010;
  localparam logic [3:0] AluAnd   = 4'b0011;
  localparam logic [3:0] AluOr    = 4'b0100;
  localparam logic [3:0] AluXor   = 4'b0101;

  // RegDst
  localparam logic [1:0] RegDstRt = 2'b00;
  localparam logic [1:0] RegDstRd = 2'b01;
  localparam logic [1:0] RegDstRa = 2'b10;

  // MemToReg
  localparam logic [1:0] MemToRegAlu  = 2'b00;
  localparam logic [1:0] MemToRegLoad = 2'b01;
  localparam logic [1:0] MemToRegLink = 2'b10;

  // LoadMux / StoreMux access width
  localparam logic [1:0] WidthWord = 2'b00;
  localparam logic [1:0] WidthHalf = 2'b01;
  localparam logic [1:0] WidthByte = 2'b10;

  // Jump
  localparam logic [1:0] JumpNone   = 2'b00;
  localparam logic [1:0] JumpTarget = 2'b01;
  localparam logic [1:0] JumpReg    = 2'b10;

  typedef struct packed {
    logic       aluSrc;
    logic [1:0] regDst;
    logic [3:0] aluOp;
    logic       memRead;
    logic       memWrite;
    logic [1:0] storeMux;
    logic       regWrite;
    logic [1:0] memToReg;
    logic [1:0] loadMux;
  } ctrl_dp_t;

  typedef struct packed {
    logic       pcSource;
    logic [1:0] jump;
  } ctrl_br_t;

  typedef struct packed {
    ctrl_dp_t dp;
    ctrl_br_t br;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational decode of instruction + ID comparator
// flags into a ctrl_bundle_t. Unlisted or illegal encodings yield all zeros.
// Ports:
//  instruction  in  32  instruction in ID
//  lessThanZero in  1   rs < 0
//  lessThanOne  in  1   rs <= 0
//  equal        in  1   rs == rt
//  bundle       out     decoded control bundle
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0]  instruction,
  input  logic         lessThanZero,
  input  logic         lessThanOne,
  input  logic         equal,
  output ctrl_bundle_t bundle
);

  logic [5:0] opcode;
  logic [4:0] rt;
  logic [5:0] funct;

  assign opcode = instruction[31:26];
  assign rt     = instruction[20:16];
  assign funct  = instruction[5:0];

  always_comb begin
    bundle = '0;
    case (opcode)
      OpRType: begin
        if (funct == FunctJr) begin
          bundle.br.jump = JumpReg;
        end else begin
          bundle.dp.regWrite = 1'b1;
          bundle.dp.regDst   = RegDstRd;
          bundle.dp.aluOp    = AluRType;
        end
      end
      OpAddi: begin
        bundle.dp.aluSrc   = 1'b1;
        bundle.dp.aluOp    = AluAdd;
        bundle.dp.regWrite = 1'b1;
      end
      OpAndi, OpOri, OpXori: begin
        bundle.dp.aluSrc   = 1'b1;
        bundle.dp.regWrite = 1'b1;
        case (opcode)
          OpAndi:  bundle.dp.aluOp = AluAnd;
          OpOri:   bundle.dp.aluOp = AluOr;
          default: bundle.dp.aluOp = AluXor;
        endcase
      end
      OpLw, OpLh, OpLb: begin
        bundle.dp.aluSrc   = 1'b1;
        bundle.dp.aluOp    = AluAdd;
        bundle.dp.memRead  = 1'b1;
        bundle.dp.regWrite = 1'b1;
        bundle.dp.memToReg = MemToRegLoad;
        case (opcode)
          OpLh:    bundle.dp.loadMux = WidthHalf;
          OpLb:    bundle.dp.loadMux = WidthByte;
          default: bundle.dp.loadMux = WidthWord;
        endcase
      end
      OpSw, OpSh, OpSb: begin
        bundle.dp.aluSrc   = 1'b1;
        bundle.dp.aluOp    = AluAdd;
        bundle.dp.memWrite = 1'b1;
        case (opcode)
          OpSh:    bundle.dp.storeMux = WidthHalf;
          OpSb:    bundle.dp.storeMux = WidthByte;
          default: bundle.dp.storeMux = WidthWord;
        endcase
      end
      OpBeq: begin
        bundle.dp.aluOp    = AluSub;
        bundle.br.pcSource = equal;
      end
      OpBgtz: begin
        bundle.dp.aluOp    = AluSub;
        bundle.br.pcSource = ~lessThanOne;
      end
      OpBlez: begin
        bundle.dp.aluOp    = AluSub;
        bundle.br.pcSource = lessThanOne;
      end
      OpRegimm: begin
        // Only bltz/bgez are implemented; other rt values stay all-zero.
        if (rt == RtBgez) begin
          bundle.dp.aluOp    = AluSub;
          bundle.br.pcSource = ~lessThanZero;
        end else if (rt == RtBltz) begin
          bundle.dp.aluOp    = AluSub;
          bundle.br.pcSource = lessThanZero;
        end
      end
      OpJ: begin
        bundle.br.jump = JumpTarget;
      end
      OpJal: begin
        bundle.br.jump     = JumpTarget;
        bundle.dp.regWrite = 1'b1;
        bundle.dp.regDst   = RegDstRa;
        bundle.dp.memToReg = MemToRegLink;
      end
      default: bundle = '0;
    endcase
  end

endmodule

// File: rtl/controller.sv
// controller: ID-stage main decode/control unit of the pipelined core.
// Decodes Instruction and resolves branches from the ID comparator flags;
// the control bundle is registered so it reaches EX one cycle later.
// Configuration macro: CONTROLLER_COMB_BRANCH_EN -- when defined, PCSource and
// Jump bypass the output register (zero latency), still forced to 0 in reset.
// Ports:
//  Clk, Rst (async, active-high)
//  Instruction, LessThanZero, LessThanOne, Equal         decode inputs
//  ALUSrc, RegDst, ALUOp, MemRead, MemWrite, StoreMux,
//  RegWrite, MemToReg, LoadMux, PCSource, Jump            control outputs
module controller
  import ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Instruction,
  input  logic        LessThanZero,
  input  logic        LessThanOne,
  input  logic        Equal,
  output logic        ALUSrc,
  output logic [1:0]  RegDst,
  output logic [3:0]  ALUOp,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  StoreMux,
  output logic        RegWrite,
  output logic [1:0]  MemToReg,
  output logic [1:0]  LoadMux,
  output logic        PCSource,
  output logic [1:0]  Jump
);

  ctrl_bundle_t decoded;
  ctrl_dp_t     dpQ;

  ctrl_decode uDecode (
    .instruction  (Instruction),
    .lessThanZero (LessThanZero),
    .lessThanOne  (LessThanOne),
    .equal        (Equal),
    .bundle       (decoded)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      dpQ <= '0;
    end else begin
      dpQ <= decoded.dp;
    end
  end

  assign ALUSrc   = dpQ.aluSrc;
  assign RegDst   = dpQ.regDst;
  assign ALUOp    = dpQ.aluOp;
  assign MemRead  = dpQ.memRead;
  assign MemWrite = dpQ.memWrite;
  assign StoreMux = dpQ.storeMux;
  assign RegWrite = dpQ.regWrite;
  assign MemToReg = dpQ.memToReg;
  assign LoadMux  = dpQ.loadMux;

`ifdef CONTROLLER_COMB_BRANCH_EN
  // Early branch resolution: steer fetch in the same cycle.
  assign PCSource = Rst ? 1'b0 : decoded.br.pcSource;
  assign Jump     = Rst ? JumpNone : decoded.br.jump;
`else
  ctrl_br_t brQ;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      brQ <= '0;
    end else begin
      brQ <= decoded.br;
    end
  end

  assign PCSource = brQ.pcSource;
  assign Jump     = brQ.jump;
`endif

endmodule

// File: tb/tb_controller.sv
// tb_controller: scoreboard bench for controller. Stimulus drives inputs on
// the falling edge and queues the hand-computed bundle; the monitor pops and
// compares one bundle just after each rising edge.
module tb_controller;

  logic        Clk;
  logic        Rst;
  logic [31:0] Instruction;
  logic        LessThanZero;
  logic        LessThanOne;
  logic        Equal;
  logic        ALUSrc;
  logic [1:0]  RegDst;
  logic [3:0]  ALUOp;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  StoreMux;
  logic        RegWrite;
  logic [1:0]  MemToReg;
  logic [1:0]  LoadMux;
  logic        PCSource;
  logic [1:0]  Jump;

  int tests  = 0;
  int failed = 0;

  logic [19:0] expQ[$];
  string       nameQ[$];

  controller dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Instruction  (Instruction),
    .LessThanZero (LessThanZero),
    .LessThanOne  (LessThanOne),
    .Equal        (Equal),
    .ALUSrc       (ALUSrc),
    .RegDst       (RegDst),
    .ALUOp        (ALUOp),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .StoreMux     (StoreMux),
    .RegWrite     (RegWrite),
    .MemToReg     (MemToReg),
    .LoadMux      (LoadMux),
    .PCSource     (PCSource),
    .Jump         (Jump)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Flat view in order: ALUSrc RegDst ALUOp MemRead MemWrite StoreMux
  // RegWrite MemToReg LoadMux PCSource Jump
  function automatic logic [19:0] ex(input logic as, input logic [1:0] rd,
                                     input logic [3:0] op, input logic mr, input logic mw,
                                     input logic [1:0] sm, input logic rw,
                                     input logic [1:0] m2r, input logic [1:0] lm,
                                     input logic pcs, input logic [1:0] jmp);
    return {as, rd, op, mr, mw, sm, rw, m2r, lm, pcs, jmp};
  endfunction

  function automatic logic [19:0] actual();
    return {ALUSrc, RegDst, ALUOp, MemRead, MemWrite, StoreMux, RegWrite, MemToReg,
            LoadMux, PCSource, Jump};
  endfunction

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %05h expected %05h", name, got, want);
    end
  endtask

  // Monitor: one registered bundle per rising edge.
  always @(posedge Clk) begin
    #1;
    if (expQ.size() != 0) begin
      logic [19:0] e;
      string       n;
      e = expQ.pop_front();
      n = nameQ.pop_front();
      check(n, actual(), e);
    end
  end

  task automatic step(input string name, input logic [31:0] instr, input logic ltz,
                      input logic lto, input logic eq, input logic [19:0] want);
    @(negedge Clk);
    Instruction  = instr;
    LessThanZero = ltz;
    LessThanOne  = lto;
    Equal        = eq;
    expQ.push_back(want);
    nameQ.push_back(name);
  endtask

  task automatic drain();
    int budget = 20;
    while (expQ.size() != 0 && budget > 0) begin
      @(negedge Clk);
      budget--;
    end
    if (expQ.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL drain: %0d entries left, expected 0", expQ.size());
      expQ.delete();
      nameQ.delete();
    end
  endtask

  initial begin
    Rst          = 1'b1;
    Instruction  = 32'h8C00_0000;
    LessThanZero = 1'b0;
    LessThanOne  = 1'b0;
    Equal        = 1'b0;

    step("reset_lw", 32'h8C00_0000, 0, 0, 0, '0);
    drain();
    @(negedge Clk);
    Rst = 1'b0;
    expQ.push_back(ex(1, 0, 4'h0, 1, 0, 0, 1, 1, 0, 0, 0));
    nameQ.push_back("lw");

    step("addi", 32'h2000_0000, 0, 0, 0, ex(1, 0, 4'h0, 0, 0, 0, 1, 0, 0, 0, 0));
    step("sw",   32'hAC00_0000, 0, 0, 0, ex(1, 0, 4'h0, 0, 1, 0, 0, 0, 0, 0, 0));
    step("sb",   32'hA000_0000, 0, 0, 0, ex(1, 0, 4'h0, 0, 1, 2, 0, 0, 0, 0, 0));
    step("sh",   32'hA400_0000, 0, 0, 0, ex(1, 0, 4'h0, 0, 1, 1, 0, 0, 0, 0, 0));
    step("lb",   32'h8000_0000, 0, 0, 0, ex(1, 0, 4'h0, 1, 0, 0, 1, 1, 2, 0, 0));
    step("lh",   32'h8400_0000, 0, 0, 0, ex(1, 0, 4'h0, 1, 0, 0, 1, 1, 1, 0, 0));
    step("andi", 32'h3000_0000, 0, 0, 0, ex(1, 0, 4'h3, 0, 0, 0, 1, 0, 0, 0, 0));
    step("ori",  32'h3400_0000, 0, 0, 0, ex(1, 0, 4'h4, 0, 0, 0, 1, 0, 0, 0, 0));
    step("xori", 32'h3800_0000, 0, 0, 0, ex(1, 0, 4'h5, 0, 0, 0, 1, 0, 0, 0, 0));

    step("beq_t",   32'h1000_0000, 0, 0, 1, ex(0, 0, 4'h1, 0, 0, 0, 0, 0, 0, 1, 0));
    step("beq_nt",  32'h1000_0000, 0, 0, 0, ex(0, 0, 4'h1, 0, 0, 0, 0, 0, 0, 0, 0));
    step("bgez_nt", 32'h0401_0000, 1, 1, 0, ex(0, 0, 4'h1, 0, 0, 0, 0, 0, 0, 0, 0));
    step("bgez_t",  32'h0401_0000, 0, 0, 0, ex(0, 0, 4'h1, 0, 0, 0, 0, 0, 0, 1, 0));
    step("bltz_t",  32'h0400_0000, 1, 1, 0, ex(0, 0, 4'h1, 0, 0, 0, 0, 0, 0, 1, 0));
    step("bltz_nt", 32'h0400_0000, 0, 0, 0, ex(0, 0, 4'h1, 0, 0, 0, 0, 0, 0, 0, 0));
    step("regimm_ill", 32'h0402_0000, 1, 1, 1, '0);
    step("bgtz_nt", 32'h1C00_0000, 0, 1, 0, ex(0, 0, 4'h1, 0, 0, 0, 0, 0, 0, 0, 0));
    step("bgtz_t",  32'h1C00_0000, 0, 0, 0, ex(0, 0, 4'h1, 0, 0, 0, 0, 0, 0, 1, 0));
    step("blez_t",  32'h1800_0000, 0, 1, 0, ex(0, 0, 4'h1, 0, 0, 0, 0, 0, 0, 1, 0));
    step("blez_nt", 32'h1800_0000, 0, 0, 1, ex(0, 0, 4'h1, 0, 0, 0, 0, 0, 0, 0, 0));

    step("jr",   32'h0000_0008, 0, 0, 0, ex(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 2));
    step("j",    32'h0800_0000, 0, 0, 0, ex(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 1));
    step("jal",  32'h0C00_0000, 0, 0, 0, ex(0, 2, 4'h0, 0, 0, 0, 1, 2, 0, 0, 1));
    step("nop",  32'h0000_0000, 0, 0, 0, ex(0, 1, 4'h2, 0, 0, 0, 1, 0, 0, 0, 0));
    step("add",  32'h0000_0020, 0, 0, 0, ex(0, 1, 4'h2, 0, 0, 0, 1, 0, 0, 0, 0));
    step("illegal", 32'hFC00_0000, 1, 1, 1, '0);
    step("jal2", 32'h0C00_0000, 0, 0, 0, ex(0, 2, 4'h0, 0, 0, 0, 1, 2, 0, 0, 1));
    drain();

    // Asynchronous reset mid-operation clears the bundle without a clock edge.
    @(negedge Clk);
    #2;
    Rst = 1'b1;
    #1;
    check("async_reset", actual(), '0);
    @(negedge Clk);
    Rst = 1'b0;
    step("after_reset_lw", 32'h8C00_0000, 0, 0, 0, ex(1, 0, 4'h0, 1, 0, 0, 1, 1, 0, 0, 0));
    drain();

`ifdef CONTROLLER_COMB_BRANCH_EN
    @(negedge Clk);
    Instruction = 32'h1000_0000;
    Equal       = 1'b1;
    #1;
    check("comb_beq", {17'h0, PCSource, Jump}, {17'h0, 1'b1, 2'b00});
    Instruction = 32'h0000_0008;
    #1;
    check("comb_jr", {17'h0, PCSource, Jump}, {17'h0, 1'b0, 2'b10});
    Instruction = 32'h1000_0000;
    Rst = 1'b1;
    #1;
    check("comb_rst", {17'h0, PCSource, Jump}, 20'h0);
    @(negedge Clk);
    Rst = 1'b0;
    drain();
`endif

    repeat (2) @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
